// File: rtl/aer_spike_serializer.sv
// rtl/aer_spike_serializer.sv - spike word to 4-phase AER event serializer with per-step markers
// Optional build macro AER_LEADING_ONE_EN: SCAN skips clear bits with a priority encoder.
module aer_spike_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 784,
  parameter int NUM_STEPS  = 16,
  parameter int ADDR_WIDTH = 12,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_parallel,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [ADDR_WIDTH-1:0] AER_IN_ADDR,
  output logic                  AER_IN_REQ,
  input  logic                  AER_IN_ACK,
  output logic [SW-1:0]         step_idx,
  output logic                  busy,
  output logic                  finish
);

  localparam int NW   = $clog2(NUM_INPUTS + 1);
  localparam int BW   = $clog2(DATA_WIDTH + 1);
  localparam int PW   = ADDR_WIDTH - 2;
  localparam int SUMW = ((NW > BW) ? NW : BW) + 1;
  localparam logic [SUMW-1:0] LIMIT     = SUMW'(NUM_INPUTS);
  localparam logic [SW-1:0]   LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [BW-1:0]   FULL      = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SCAN,
    S_REQ,
    S_RELEASE,
    S_TS_REQ,
    S_TS_RELEASE
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sreg, sreg_nxt;     // current bit is always the MSB
  logic [BW-1:0]         rem, rem_nxt;       // word bits left, current one included
  logic [NW-1:0]         idx, idx_nxt;       // neuron index of the current bit
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  req, req_nxt;
  logic [SW-1:0]         step, step_nxt;
  logic                  fin, fin_nxt;

  logic                  adv_en;
  logic [BW-1:0]         adv_d;
  logic [SUMW-1:0]       sum;

`ifdef AER_LEADING_ONE_EN
  logic                  lead_found;
  logic [BW-1:0]         lead_dist;

  // Distance from the current bit to the nearest set bit behind it (smallest wins)
  always_comb begin
    lead_found = 1'b0;
    lead_dist  = '0;
    for (int k = DATA_WIDTH - 1; k >= 1; k--) begin
      if (sreg[DATA_WIDTH-1-k]) begin
        lead_found = 1'b1;
        lead_dist  = BW'(k);
      end
    end
  end
`endif

  // State and datapath registers; reset drops REQ without waiting for the core
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      sreg  <= '0;
      rem   <= '0;
      idx   <= '0;
      addr  <= '0;
      req   <= 1'b0;
      step  <= '0;
      fin   <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      rem   <= rem_nxt;
      idx   <= idx_nxt;
      addr  <= addr_nxt;
      req   <= req_nxt;
      step  <= step_nxt;
      fin   <= fin_nxt;
    end
  end

  // Next-state logic: handshakes, bit scanning and end-of-word / end-of-step decisions
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    rem_nxt   = rem;
    idx_nxt   = idx;
    addr_nxt  = addr;
    req_nxt   = req;
    step_nxt  = step;
    fin_nxt   = 1'b0;
    adv_en    = 1'b0;
    adv_d     = BW'(1);
    sum       = '0;

    case (state)
      S_LOAD: begin
        if (din_valid) begin
          sreg_nxt  = din_parallel;
          rem_nxt   = FULL;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (sreg[DATA_WIDTH-1]) begin
          // a stray ACK from the core holds off the next request
          if (!AER_IN_ACK) begin
            addr_nxt  = {2'b00, PW'(idx)};
            req_nxt   = 1'b1;
            state_nxt = S_REQ;
          end
        end else begin
          adv_en = 1'b1;
`ifdef AER_LEADING_ONE_EN
          adv_d  = lead_found ? lead_dist : rem;
`endif
        end
      end
      S_REQ: begin
        if (AER_IN_ACK) begin
          req_nxt   = 1'b0;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!AER_IN_ACK) begin
          adv_en = 1'b1;
        end
      end
      S_TS_REQ: begin
        if (!req && !AER_IN_ACK) begin
          addr_nxt = {2'b01, PW'(step)};
          req_nxt  = 1'b1;
        end else if (req && AER_IN_ACK) begin
          req_nxt   = 1'b0;
          state_nxt = S_TS_RELEASE;
        end
      end
      S_TS_RELEASE: begin
        if (!AER_IN_ACK) begin
          step_nxt  = (step == LAST_STEP) ? '0 : step + 1'b1;
          fin_nxt   = (step == LAST_STEP);
          idx_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase

    // Move past adv_d bits: the step limit wins over the end of the word
    if (adv_en) begin
      sum = SUMW'(idx) + SUMW'(adv_d);
      if (sum >= LIMIT) begin
        state_nxt = S_TS_REQ;
      end else begin
        idx_nxt = NW'(sum);
        if (adv_d >= rem) begin
          state_nxt = S_LOAD;
        end else begin
          sreg_nxt  = sreg << adv_d;
          rem_nxt   = rem - adv_d;
          state_nxt = S_SCAN;
        end
      end
    end
  end

  assign din_ready   = (state == S_LOAD);
  assign busy        = (state != S_LOAD);
  assign AER_IN_ADDR = addr;
  assign AER_IN_REQ  = req;
  assign step_idx    = step;
  assign finish      = fin;

endmodule

// File: tb/tb_aer_spike_serializer.sv
// tb/tb_aer_spike_serializer.sv - self-checking bench for aer_spike_serializer
module tb_aer_spike_serializer;

  localparam int DW = 8;
  localparam int NI = 12;
  localparam int NS = 2;
  localparam int AW = 12;
  localparam int SW = 1;
`ifdef AER_LEADING_ONE_EN
  localparam int LAT_LSB = 2;
`else
  localparam int LAT_LSB = 8;
`endif

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din_parallel = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [AW-1:0] AER_IN_ADDR;
  logic          AER_IN_REQ;
  logic          AER_IN_ACK = 1'b0;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          finish;

  aer_spike_serializer #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_STEPS(NS), .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .din_parallel(din_parallel), .din_valid(din_valid), .din_ready(din_ready),
    .AER_IN_ADDR(AER_IN_ADDR), .AER_IN_REQ(AER_IN_REQ), .AER_IN_ACK(AER_IN_ACK),
    .step_idx(step_idx), .busy(busy), .finish(finish)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  // reference model state: expected event queue built from words as they are offered
  int exp_q[$];
  int log_q[$];
  int m_idx = 0, m_step = 0, exp_finish = 0;
  int markers = 0, got_finish = 0;

  bit hold_ack = 0, fixed_ack = 0, stray_en = 0, arm_rise = 0;
  int ack_dly = 1, ack_hold = 1;
  int first_rise_cyc = 0, cap_cyc = 0, last_dur = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // one event per set bit below NUM_INPUTS, marker once the step's neurons are covered
  function automatic void model_word(input logic [DW-1:0] w);
    for (int b = 0; b < DW; b++) begin
      if (m_idx + b >= NI) break;
      if (w[DW-1-b]) exp_q.push_back(m_idx + b);
    end
    m_idx += DW;
    if (m_idx >= NI) begin
      exp_q.push_back(32'h400 | m_step);
      m_idx = 0;
      if (m_step == NS - 1) begin
        exp_finish++;
        m_step = 0;
      end else begin
        m_step++;
      end
    end
  endfunction

  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    @(negedge CLK);
    din_parallel = w;
    din_valid = 1'b1;
    while (!din_ready && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!din_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: din_ready stayed %0b, required 1", din_ready);
      din_valid = 1'b0;
      return;
    end
    model_word(w);
    @(posedge CLK);
    #1;
    cap_cyc = cyc;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !din_ready) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || !din_ready) begin
      errors++;
      $display("FAIL drain_timeout: %0d events outstanding, din_ready %0b, required 0 and 1",
               exp_q.size(), din_ready);
    end
  endtask

  task automatic wait_log(input int cnt);
    int n = 0;
    while (log_q.size() < cnt && n < 500) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (log_q.size() < cnt) begin
      errors++;
      $display("FAIL event_timeout: saw %0d events, required %0d", log_q.size(), cnt);
    end
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_count"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp[i]);
  endtask

  // core-side acknowledge: delayed ACK per REQ, optional stray pulses while idle
  initial begin
    int d, h, n;
    forever begin
      @(negedge CLK);
      if (rst_n && AER_IN_REQ && !AER_IN_ACK && !hold_ack) begin
        d = fixed_ack ? ack_dly : int'($urandom_range(1, 4));
        h = fixed_ack ? ack_hold : int'($urandom_range(1, 3));
        repeat (d - 1) @(negedge CLK);
        if (!rst_n) continue;
        AER_IN_ACK = 1'b1;
        repeat (h) @(negedge CLK);
        n = 0;
        while (AER_IN_REQ && rst_n && n < 200) begin
          @(negedge CLK);
          n++;
        end
        AER_IN_ACK = 1'b0;
      end else if (rst_n && stray_en && !AER_IN_REQ && ($urandom % 8 == 0)) begin
        AER_IN_ACK = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
        AER_IN_ACK = 1'b0;
      end
    end
  end

  // compare process: every cycle just after the clock edge
  initial begin
    logic          prev_req;
    logic [AW-1:0] held;
    int            dur;
    prev_req = 1'b0;
    held = '0;
    dur = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!rst_n) begin
        prev_req = 1'b0;
        dur = 0;
        continue;
      end
      check("ready_vs_busy", din_ready, !busy);
      if (AER_IN_REQ && !prev_req) begin
        log_q.push_back(AER_IN_ADDR);
        if (arm_rise) begin
          first_rise_cyc = cyc;
          arm_rise = 0;
        end
        check("req_rise_with_ack_low", AER_IN_ACK, 1'b0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_event: addr %0h, required no event", AER_IN_ADDR);
        end else begin
          check("event_addr", AER_IN_ADDR, exp_q.pop_front());
        end
        if (AER_IN_ADDR[AW-1:AW-2] == 2'b01) markers++;
        held = AER_IN_ADDR;
        dur = 1;
      end else if (AER_IN_REQ) begin
        check("addr_stable", AER_IN_ADDR, held);
        dur++;
      end else if (prev_req) begin
        last_dur = dur;
      end
      if (din_ready) check("step_idx", step_idx, markers % NS);
      if (finish) begin
        got_finish++;
        check("finish_step_wrap", step_idx, 0);
        check("finish_after_last_marker", held, 12'h401);
      end
      prev_req = AER_IN_REQ;
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check("rst_din_ready", din_ready, 1);
    check("rst_req", AER_IN_REQ, 0);
    check("rst_addr", AER_IN_ADDR, 0);
    check("rst_step", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    @(negedge CLK);
    rst_n = 1'b1;

    // step 0: 8'h81 then 8'hFF, neurons 12..15 dropped
    fixed_ack = 1; ack_dly = 1; ack_hold = 1;
    log_q.delete();
    arm_rise = 1;
    send(8'h81);
    wait_log(1);
    check("latency_msb", first_rise_cyc - cap_cyc, 1);
    send(8'hFF);
    drain();
    check_log("step0_events", '{12'h000, 12'h007, 12'h008, 12'h009, 12'h00A, 12'h00B, 12'h400});
    check("step0_idx", step_idx, 1);
    check("step0_no_finish", got_finish, 0);

    // step 1: only neuron 11 set, finish pulse and wrap
    log_q.delete();
    send(8'h00);
    send(8'h10);
    drain();
    check_log("step1_events", '{12'h00B, 12'h401});
    check("step1_finish", got_finish, 1);
    check("step1_wrap", step_idx, 0);

    // slow core: ACK after 5 cycles, held 3 cycles
    ack_dly = 5; ack_hold = 3;
    log_q.delete();
    send(8'hC0);
    wait_log(2);
    check("req_hold_5", last_dur, 5);
    send(8'h00);
    drain();
    check("req_hold_marker", last_dur, 5);
    check_log("slow_events", '{12'h000, 12'h001, 12'h400});

    // lowest bit only: scan latency
    ack_dly = 1; ack_hold = 1;
    log_q.delete();
    arm_rise = 1;
    send(8'h01);
    wait_log(1);
    check("latency_lsb", first_rise_cyc - cap_cyc, LAT_LSB);
    send(8'h00);
    drain();
    check_log("lsb_events", '{12'h007, 12'h401});

    // randomized steps with random ACK timing and stray ACK pulses
    fixed_ack = 0;
    stray_en = 1;
    for (int s = 0; s < 30; s++) begin
      for (int w = 0; w < 2; w++) begin
        logic [DW-1:0] word;
        case ($urandom % 4)
          0: word = '0;
          1: word = DW'($urandom);
          2: word = DW'(1) << $urandom_range(0, DW - 1);
          default: word = '1;
        endcase
        send(word);
      end
    end
    drain();
    stray_en = 0;
    repeat (4) @(negedge CLK);
    check("finish_count", got_finish, exp_finish);

    // reset while REQ is held high
    hold_ack = 1;
    send(8'h80);
    begin
      int n = 0;
      while (!AER_IN_REQ && n < 50) begin
        @(negedge CLK);
        n++;
      end
    end
    check("req_before_reset", AER_IN_REQ, 1);
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    check("midrst_req", AER_IN_REQ, 0);
    check("midrst_ready", din_ready, 1);
    check("midrst_step", step_idx, 0);
    exp_q.delete();
    m_idx = 0;
    m_step = 0;
    markers = 0;
    @(negedge CLK);
    rst_n = 1'b1;
    hold_ack = 0;
    log_q.delete();
    send(8'h40);
    send(8'h00);
    drain();
    check_log("restart_events", '{12'h001, 12'h400});
    check("restart_step", step_idx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
